// File: rtl/inst_fetch_responder_pkg.sv
// Shared widths and state encoding for the instruction-fetch responder.
//
// Contents:
//   IFR_ADDR_W   - width of the fetch byte address (MemAddrBus)
//   IFR_MEM_A_W  - width of the RAM byte address actually driven out
//   IFR_INST_W   - width of an assembled instruction (InstBus)
//   IFR_BYTE_W   - width of one RAM data byte (ByteBus)
//   ifr_state_e  - responder FSM states (IFR_IDLE, IFR_FETCH, IFR_DONE)
package inst_fetch_responder_pkg;

    localparam int IFR_ADDR_W  = 32;
    localparam int IFR_MEM_A_W = 17;
    localparam int IFR_INST_W  = 32;
    localparam int IFR_BYTE_W  = 8;

    typedef enum logic [1:0] {
        IFR_IDLE  = 2'd0,
        IFR_FETCH = 2'd1,
        IFR_DONE  = 2'd2
    } ifr_state_e;

endpackage

// File: rtl/inst_fetch_responder.sv
// Memory-side responder for instruction fetch.
//
// Accepts a fetch request, reads four consecutive bytes over the byte-wide
// shared RAM port and returns them as one little-endian 32-bit instruction.
//
// Handshake: ram_read is a level request; the requester holds ram_read high
// with ram_addr stable until it sees ram_ready, a single-cycle pulse during
// which ram_data is valid. Dropping ram_read before that aborts the fetch;
// changing ram_addr restarts it at the new address. On the RAM side, a byte
// read is issued (mem_rd) only in cycles where mem_grant is high, and its
// data on mem_din is valid exactly one cycle later.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   ram_read   in   fetch request (level)
//   ram_addr   in   instruction byte address
//   ram_ready  out  one-cycle pulse, ram_data valid
//   ram_data   out  assembled instruction, held until next completion
//   mem_grant  in   RAM port owned by this block this cycle
//   mem_rd     out  byte read strobe
//   mem_a      out  RAM byte address
//   mem_din    in   RAM read data, one cycle after mem_rd
//   dbg_state  out  current FSM state (ifr_state_e encoding)
module inst_fetch_responder
    import inst_fetch_responder_pkg::*;
#(
    parameter int ADDR_W  = IFR_ADDR_W,
    parameter int MEM_A_W = IFR_MEM_A_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ram_read,
    input  logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_ready,
    output logic [31:0]        ram_data,
    input  logic               mem_grant,
    output logic               mem_rd,
    output logic [MEM_A_W-1:0] mem_a,
    input  logic [7:0]         mem_din,
    output logic [1:0]         dbg_state
);

    ifr_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [2:0]         issue_cnt_q, issue_cnt_d;
    logic [1:0]         recv_cnt_q, recv_cnt_d;
    logic               pend_q, pend_d;
    logic [23:0]        buf_q, buf_d;
    logic               ram_ready_q, ram_ready_d;
    logic [31:0]        ram_data_q, ram_data_d;

    logic               issue_ok;
    logic [MEM_A_W-1:0] issue_addr;

    // The full address wraps modulo 2^ADDR_W, so its low MEM_A_W bits are
    // exactly the low-bit sum; only those bits are ever driven out.
    always_comb begin
        issue_addr = base_q[MEM_A_W-1:0] + MEM_A_W'(issue_cnt_q);
        issue_ok   = (state_q == IFR_FETCH) && mem_grant && (issue_cnt_q < 3'd4);
        mem_rd     = issue_ok;
        mem_a      = issue_ok ? issue_addr : '0;
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        pend_d      = pend_q;
        buf_d       = buf_q;
        ram_ready_d = 1'b0;
        ram_data_d  = ram_data_q;

        case (state_q)
            IFR_IDLE: begin
                if (ram_read) begin
                    base_d      = ram_addr;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    pend_d      = 1'b0;
                    state_d     = IFR_FETCH;
                end
            end

            IFR_FETCH: begin
                // Abort and restart win over byte capture: any byte still in
                // flight belongs to the abandoned request and is dropped.
                if (!ram_read) begin
                    state_d     = IFR_IDLE;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    pend_d      = 1'b0;
                end else if (ram_addr != base_q) begin
                    base_d      = ram_addr;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    pend_d      = 1'b0;
                end else begin
                    if (issue_ok) begin
                        issue_cnt_d = issue_cnt_q + 3'd1;
                    end
                    pend_d = issue_ok;

                    if (pend_q) begin
                        if (recv_cnt_q == 2'd3) begin
                            // Last byte goes straight into the output register.
                            ram_data_d  = {mem_din, buf_q};
                            ram_ready_d = 1'b1;
                            recv_cnt_d  = '0;
                            state_d     = IFR_DONE;
                        end else begin
                            case (recv_cnt_q)
                                2'd0:    buf_d[7:0]   = mem_din;
                                2'd1:    buf_d[15:8]  = mem_din;
                                default: buf_d[23:16] = mem_din;
                            endcase
                            recv_cnt_d = recv_cnt_q + 2'd1;
                        end
                    end
                end
            end

            IFR_DONE: begin
                // One-cycle ready pulse; a still-present request is
                // picked up again from IDLE.
                state_d = IFR_IDLE;
            end

            default: begin
                state_d = IFR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IFR_IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            pend_q      <= 1'b0;
            buf_q       <= '0;
            ram_ready_q <= 1'b0;
            ram_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            pend_q      <= pend_d;
            buf_q       <= buf_d;
            ram_ready_q <= ram_ready_d;
            ram_data_q  <= ram_data_d;
        end
    end

    assign ram_ready = ram_ready_q;
    assign ram_data  = ram_data_q;
    assign dbg_state = state_q;

endmodule
